vpu_fp_dst_port: RTL and testbench
==================================

Name: vpu_fp_dst_port

Overview:
- Destination-side companion for a VPU fixed-latency FP op unit.
- The op unit (for example, the 3-operand average) takes operands plus a start pulse and returns a result with a done pulse. It has no backpressure.
- This block gates issue with credits so that every started op has a guaranteed result slot.
- It captures result/done into a FIFO and drains the FIFO to the writeback bus over a valid/ready handshake.

Parameters:
- DATA_WIDTH, default VPU_PKG::OPERAND_WIDTH (16): result width in bits.
- DEPTH, default 8: result FIFO entries and total credits. Must be a power of 2, ≥2.
- CNT_W, default $clog2(DEPTH)+1: width of the credit, inflight and occupancy counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- issue_valid_i  in  1  source port requests to start one op.
- issue_ready_o  out  1  a credit is available; issue accepted when valid&ready.
- start_o  out  1  start pulse to the op unit; equals issue_valid_i & issue_ready_o.
- done_i  in  1  result-valid pulse from the op unit.
- result_i  in  DATA_WIDTH  result from the op unit; sampled when done_i=1.
- wb_valid_o  out  1  FIFO head valid.
- wb_data_o  out  DATA_WIDTH  FIFO head data.
- wb_ready_i  in  1  writeback accepts; pop when wb_valid_o & wb_ready_i.
- busy_o  out  1  ops are inflight or buffered.
- err_o  out  1  sticky protocol error.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst=1 at a clk edge):
  - inflight_cnt, fifo_cnt, read/write pointers and err_o go to 0.
  - wb_data_o goes to 0.
  - While rst=1: issue_ready_o=0, start_o=0, wb_valid_o=0, busy_o=0.
  - First cycle after reset release: issue_ready_o=1.
- Credit accounting:
  - credits = DEPTH − inflight_cnt − fifo_cnt.
  - issue_ready_o = (credits≠0), combinational from registered counters.
  - It does not depend on issue_valid_i, so there is no comb loop.
- inflight_cnt update per cycle:
  - +1 on an accepted issue.
  - −1 on done_i while inflight_cnt≠0.
  - Both in the same cycle: unchanged.
- fifo_cnt update per cycle:
  - +1 on a valid write (done_i with inflight_cnt≠0).
  - −1 on a pop.
  - Both in the same cycle: unchanged.
- A credit returns only on pop, never on done. Invariant: inflight_cnt + fifo_cnt ≤ DEPTH.
- FIFO:
  - Show-ahead; a write stores result_i at wr_ptr.
  - Latency: done_i at edge N gives wb_valid_o=1 with wb_data_o=result at N+1. There is no bypass path.
  - wb_data_o is the registered head. On pop, the next entry appears the following cycle, so back-to-back pops drain one entry per cycle.
  - Write and pop in the same cycle are allowed at any occupancy, including full. The entry is written into the slot being freed only if the pointers permit; the credit invariant guarantees a legal write never targets an occupied slot.
  - Pointers wrap modulo DEPTH.
- wb_valid_o = (fifo_cnt≠0). The head holds stable while wb_valid_o=1 and wb_ready_i=0.
- busy_o = (inflight_cnt≠0) | (fifo_cnt≠0).
- Errors (set err_o, which holds until reset):
  - done_i with inflight_cnt=0: spurious result. It is dropped and no counter changes.
  - done_i while fifo_cnt=DEPTH with no pop that cycle: overflow. It is dropped. This is unreachable under legal op-unit behaviour.
- Reset mid-operation discards all inflight and buffered results. A done_i arriving after reset release for an op issued before reset counts as spurious and sets err_o. The source port is responsible for quiescing the op unit first.

Test Plan:
- Reset, then 3 issues with op latency L=5 returning 0x3F80, 0x4000, 0x4040, wb_ready_i=1. Required: each wb_valid_o one cycle after its done_i, data in order, busy_o falls the cycle after the last pop, err_o=0.
- DEPTH=8, wb_ready_i=0, issue_valid_i held high. Required: exactly 8 start_o pulses, then issue_ready_o=0. All 8 results buffered, wb_data_o=first result and stable.
- From the full state, raise wb_ready_i for 1 cycle. Required: one pop, issue_ready_o=1 the next cycle, one new start_o. Its result is written while another pop happens in the same cycle with no loss, and fifo_cnt stays consistent.
- Continuous stream for 20 ops with wb_ready_i=1 and issue held. Required: throughput 1 op/cycle after fill, pointer wrap preserves order (sequence 0x0001..0x0014).
- done_i pulse with nothing issued. Required: err_o=1 next cycle and stays 1, wb_valid_o stays 0, counters unchanged.
- Assert rst with 4 buffered and 2 inflight. Required: next cycle wb_valid_o=0, busy_o=0, err_o=0. After release, issue_ready_o=1 and a late done_i sets err_o.

Source files
------------

// File: rtl/vpu_fp_dst_port.sv
// rtl/vpu_fp_dst_port.sv - credit-gated issue and result FIFO for a fixed-latency VPU op unit
// Every started op owns a result slot; results drain to writeback over valid/ready.
module vpu_fp_dst_port #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid_i,
  output logic                  issue_ready_o,
  output logic                  start_o,
  input  logic                  done_i,
  input  logic [DATA_WIDTH-1:0] result_i,
  output logic                  wb_valid_o,
  output logic [DATA_WIDTH-1:0] wb_data_o,
  input  logic                  wb_ready_i,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [CNT_W-1:0]      inflight_cnt, fifo_cnt, credits;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  err_q;
  logic                  pop, done_ok, spurious, overflow, wr_en, head_load;

  // Credits come back only on pop, so a started op always finds a free slot.
  assign credits       = DEPTH_C - inflight_cnt - fifo_cnt;
  assign issue_ready_o = ~rst & (credits != '0);
  assign start_o       = issue_valid_i & issue_ready_o;
  assign wb_valid_o    = ~rst & (fifo_cnt != '0);
  assign busy_o        = ~rst & ((inflight_cnt != '0) | (fifo_cnt != '0));
  assign err_o         = err_q;

  assign pop        = wb_valid_o & wb_ready_i;
  assign done_ok    = done_i & (inflight_cnt != '0);
  assign spurious   = done_i & (inflight_cnt == '0);
  assign overflow   = done_ok & (fifo_cnt == DEPTH_C) & ~pop;
  assign wr_en      = done_ok & ~overflow;
  assign rd_ptr_nxt = rd_ptr + PTR_ONE;

  // The incoming result becomes the head when the FIFO is (or is about to be) empty.
  assign head_load = wr_en & ((fifo_cnt == '0) | ((fifo_cnt == CNT_ONE) & pop));

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_cnt <= '0;
      fifo_cnt     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      err_q        <= 1'b0;
      wb_data_o    <= '0;
    end else begin
      case ({start_o, done_ok})
        2'b10:   inflight_cnt <= inflight_cnt + CNT_ONE;
        2'b01:   inflight_cnt <= inflight_cnt - CNT_ONE;
        default: inflight_cnt <= inflight_cnt;
      endcase
      case ({wr_en, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
        2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr_nxt;
      if (spurious | overflow) err_q <= 1'b1;
      if (head_load)
        wb_data_o <= result_i;
      else if (pop && (fifo_cnt > CNT_ONE))
        wb_data_o <= mem[rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem[wr_ptr] <= result_i;
  end

endmodule

// File: tb/tb_vpu_fp_dst_port.sv
// tb/tb_vpu_fp_dst_port.sv - scoreboard bench for vpu_fp_dst_port
// Driver models the op unit and pushes expected results; a negedge monitor checks them.
module tb_vpu_fp_dst_port;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int L     = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          issue_valid_i = 1'b0;
  logic          issue_ready_o, start_o;
  logic          done_i = 1'b0;
  logic [DW-1:0] result_i = '0;
  logic          wb_valid_o;
  logic [DW-1:0] wb_data_o;
  logic          wb_ready_i = 1'b0;
  logic          busy_o, err_o;

  vpu_fp_dst_port #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o), .start_o(start_o),
    .done_i(done_i), .result_i(result_i),
    .wb_valid_o(wb_valid_o), .wb_data_o(wb_data_o), .wb_ready_i(wb_ready_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic [DW-1:0] val;
  } op_t;

  op_t           op_q[$];
  logic [DW-1:0] exp_q[$];
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock of stimulus; the op unit returns each accepted op exactly L cycles later.
  task automatic step(input logic r, input logic iv, input logic wr, input logic [DW-1:0] v,
                      input logic spur, output logic acc);
    @(posedge clk);
    cyc++;
    #1;
    rst           = r;
    issue_valid_i = iv;
    wb_ready_i    = wr;
    if (op_q.size() != 0 && op_q[0].due == cyc) begin
      done_i   = 1'b1;
      result_i = op_q[0].val;
      void'(op_q.pop_front());
    end else begin
      done_i   = spur;
      result_i = DW'($urandom);
    end
    #1;
    acc = start_o;
    if (acc) begin
      op_q.push_back('{cyc + L, v});
      exp_q.push_back(v);
    end
  endtask

  task automatic drain();
    int   n = 0;
    logic a;
    while ((op_q.size() != 0 || exp_q.size() != 0) && n < 300) begin
      step(1'b0, 1'b0, 1'b1, '0, 1'b0, a);
      n++;
    end
    step(1'b0, 1'b0, 1'b1, '0, 1'b0, a);
    chk("drain_in_time", int'(n < 300), 1);
  endtask

  // Reference: outstanding = issued-but-not-popped, buffered = returned-but-not-popped.
  int   out_m = 0;
  int   buf_m = 0;
  logic err_m = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_issue_ready", issue_ready_o, 0);
        chk("rst_start", start_o, 0);
        chk("rst_wb_valid", wb_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        out_m = 0;
        buf_m = 0;
        err_m = 1'b0;
        exp_q.delete();
      end else begin
        logic pop_m, iss_m;
        iss_m = issue_valid_i && (out_m < DEPTH);
        pop_m = (buf_m != 0) && wb_ready_i;
        chk("issue_ready", issue_ready_o, int'(out_m < DEPTH));
        chk("start", start_o, int'(iss_m));
        chk("wb_valid", wb_valid_o, int'(buf_m != 0));
        chk("busy", busy_o, int'(out_m != 0));
        chk("err", err_o, int'(err_m));
        if (buf_m != 0 && exp_q.size() != 0) chk("wb_data", wb_data_o, exp_q[0]);
        if (done_i) begin
          if (out_m - buf_m == 0) err_m = 1'b1;
          else buf_m++;
        end
        if (iss_m) out_m++;
        if (pop_m) begin
          out_m--;
          buf_m--;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          a;
    int            ns;
    logic [DW-1:0] seq;
    logic [DW-1:0] t1 [3];
    t1[0] = 16'h3F80; t1[1] = 16'h4000; t1[2] = 16'h4040;

    step(1'b1, 1'b0, 1'b0, '0, 1'b0, a);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, a);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, a);
    chk("reset_wb_data", wb_data_o, 0);

    // Three ops with known results, writeback always ready.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, t1[i], 1'b0, a);
    drain();

    // Fill all credits with writeback stalled.
    ns = 0;
    for (int i = 0; i < 18; i++) begin
      step(1'b0, 1'b1, 1'b0, DW'($urandom), 1'b0, a);
      if (a) ns++;
    end
    chk("fill_starts", ns, DEPTH);
    step(1'b0, 1'b1, 1'b1, DW'($urandom), 1'b0, a);
    chk("full_no_start", a, 0);
    step(1'b0, 1'b1, 1'b0, DW'($urandom), 1'b0, a);
    chk("refill_start", a, 1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b0, a);
    drain();

    // Streaming: one op per cycle, ordered 0x0001..0x0014 across pointer wrap.
    ns  = 0;
    seq = 16'h0001;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 1'b1, seq, 1'b0, a);
      if (a) begin
        ns++;
        seq++;
      end
    end
    chk("stream_starts", ns, 20);
    drain();

    // Random issue and writeback pressure.
    for (int i = 0; i < 400; i++)
      step(1'b0, logic'($urandom_range(0, 1)), logic'(($urandom % 4) != 0),
           DW'($urandom), 1'b0, a);
    drain();

    // Spurious done with nothing in flight.
    step(1'b0, 1'b0, 1'b1, '0, 1'b1, a);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, '0, 1'b0, a);
    chk("spurious_err_sticky", err_o, 1);

    // Reset with 4 buffered and 2 in flight; the late return must flag an error.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, DW'($urandom), 1'b0, a);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b0, a);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, a);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, a);
    chk("post_reset_wb_data", wb_data_o, 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b0, a);
    chk("late_done_err", err_o, 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
